// File: rtl/id_ex_pipe_reg.sv
`default_nettype none
// ============================================================================
// Module   : id_ex_pipe_reg
// Purpose  : Decode/Execute pipeline register of the 5-stage MIPS core.
//            Captures the decode-stage control word, register-file operands,
//            register specifiers and sign-extended immediate, and presents
//            them to the execute stage one cycle later. Supports stall (hold)
//            and flush (bubble insertion) from the hazard unit, and keeps a
//            saturating count of inserted bubbles for debug.
// Ports    :
//   i_CLK, i_RST              clock, synchronous active-high reset
//   i_StallE / i_FlushE       hazard-unit hold / bubble requests
//   i_<ctrl>D                 decode control word (RegWrite, MemtoReg,
//                             MemWrite, ALUControl[2:0], ALUSrc, RegDst,
//                             Branch)
//   i_RD1D, i_RD2D, i_SignImmD  DATA_WIDTH datapath fields
//   i_RsD, i_RtD, i_RdD       REG_AW register specifiers
//   o_<field>E                registered copy of each decode input
//   o_ValidE                  1 = execute slot holds a real instruction
//   o_BubbleCnt               saturating count of flush-inserted bubbles
// Revision : 1.0  initial release
// ============================================================================
module id_ex_pipe_reg #(
    parameter int DATA_WIDTH = 32,
    parameter int REG_AW     = 5,
    parameter int CNT_W      = 16
) (
    input  logic                  i_CLK,
    input  logic                  i_RST,
    input  logic                  i_StallE,
    input  logic                  i_FlushE,
    input  logic                  i_RegWriteD,
    input  logic                  i_MemtoRegD,
    input  logic                  i_MemWriteD,
    input  logic [2:0]            i_ALUControlD,
    input  logic                  i_ALUSrcD,
    input  logic                  i_RegDstD,
    input  logic                  i_BranchD,
    input  logic [DATA_WIDTH-1:0] i_RD1D,
    input  logic [DATA_WIDTH-1:0] i_RD2D,
    input  logic [REG_AW-1:0]     i_RsD,
    input  logic [REG_AW-1:0]     i_RtD,
    input  logic [REG_AW-1:0]     i_RdD,
    input  logic [DATA_WIDTH-1:0] i_SignImmD,
    output logic                  o_RegWriteE,
    output logic                  o_MemtoRegE,
    output logic                  o_MemWriteE,
    output logic [2:0]            o_ALUControlE,
    output logic                  o_ALUSrcE,
    output logic                  o_RegDstE,
    output logic                  o_BranchE,
    output logic [DATA_WIDTH-1:0] o_RD1E,
    output logic [DATA_WIDTH-1:0] o_RD2E,
    output logic [REG_AW-1:0]     o_RsE,
    output logic [REG_AW-1:0]     o_RtE,
    output logic [REG_AW-1:0]     o_RdE,
    output logic [DATA_WIDTH-1:0] o_SignImmE,
    output logic                  o_ValidE,
    output logic [CNT_W-1:0]      o_BubbleCnt
);

    localparam logic [CNT_W-1:0] c_CNT_MAX = '1;
    localparam logic [CNT_W-1:0] c_CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    // Every output is a flop; nothing from the inputs reaches an output
    // without passing through this register.
    always_ff @(posedge i_CLK) begin
        if (i_RST) begin
            o_RegWriteE   <= 1'b0;
            o_MemtoRegE   <= 1'b0;
            o_MemWriteE   <= 1'b0;
            o_ALUControlE <= 3'b000;
            o_ALUSrcE     <= 1'b0;
            o_RegDstE     <= 1'b0;
            o_BranchE     <= 1'b0;
            o_RD1E        <= '0;
            o_RD2E        <= '0;
            o_RsE         <= '0;
            o_RtE         <= '0;
            o_RdE         <= '0;
            o_SignImmE    <= '0;
            o_ValidE      <= 1'b0;
            o_BubbleCnt   <= '0;
        end else if (i_FlushE) begin
            // Bubble: constants only, so undefined decode data cannot leak
            // into the execute stage. Flush overrides a concurrent stall.
            o_RegWriteE   <= 1'b0;
            o_MemtoRegE   <= 1'b0;
            o_MemWriteE   <= 1'b0;
            o_ALUControlE <= 3'b000;
            o_ALUSrcE     <= 1'b0;
            o_RegDstE     <= 1'b0;
            o_BranchE     <= 1'b0;
            o_RD1E        <= '0;
            o_RD2E        <= '0;
            o_RsE         <= '0;
            o_RtE         <= '0;
            o_RdE         <= '0;
            o_SignImmE    <= '0;
            o_ValidE      <= 1'b0;
            // Saturate rather than wrap so a long flush storm stays visible.
            if (o_BubbleCnt != c_CNT_MAX) begin
                o_BubbleCnt <= o_BubbleCnt + c_CNT_ONE;
            end
        end else if (!i_StallE) begin
            o_RegWriteE   <= i_RegWriteD;
            o_MemtoRegE   <= i_MemtoRegD;
            o_MemWriteE   <= i_MemWriteD;
            o_ALUControlE <= i_ALUControlD;
            o_ALUSrcE     <= i_ALUSrcD;
            o_RegDstE     <= i_RegDstD;
            o_BranchE     <= i_BranchD;
            o_RD1E        <= i_RD1D;
            o_RD2E        <= i_RD2D;
            o_RsE         <= i_RsD;
            o_RtE         <= i_RtD;
            o_RdE         <= i_RdD;
            o_SignImmE    <= i_SignImmD;
            o_ValidE      <= 1'b1;
        end
        // Stall without flush: every flop, including the counter, holds.
    end

endmodule
`default_nettype wire

// File: tb/tb_id_ex_pipe_reg.sv
`default_nettype none
// ============================================================================
// Module   : tb_id_ex_pipe_reg
// Purpose  : Self-checking bench for id_ex_pipe_reg. Directed scenarios
//            followed by randomized traffic, compared against a slot-level
//            reference model after every clock edge.
// Revision : 1.0  initial release
// ============================================================================
module tb_id_ex_pipe_reg;

    localparam int DATA_WIDTH = 32;
    localparam int REG_AW     = 5;
    localparam int CNT_W      = 4;
    localparam int CNT_MAX    = (1 << CNT_W) - 1;

    typedef struct packed {
        logic                  regWrite;
        logic                  memtoReg;
        logic                  memWrite;
        logic [2:0]            aluControl;
        logic                  aluSrc;
        logic                  regDst;
        logic                  branch;
        logic [DATA_WIDTH-1:0] rd1;
        logic [DATA_WIDTH-1:0] rd2;
        logic [REG_AW-1:0]     rs;
        logic [REG_AW-1:0]     rt;
        logic [REG_AW-1:0]     rd;
        logic [DATA_WIDTH-1:0] signImm;
    } slot_t;

    logic  clk = 1'b0;
    logic  rst, stall, flush;
    slot_t din;

    logic                  regWriteE, memtoRegE, memWriteE, aluSrcE, regDstE, branchE;
    logic [2:0]            aluControlE;
    logic [DATA_WIDTH-1:0] rd1E, rd2E, signImmE;
    logic [REG_AW-1:0]     rsE, rtE, rdE;
    logic                  validE;
    logic [CNT_W-1:0]      bubbleCnt;
    slot_t                 obs;

    assign obs = {regWriteE, memtoRegE, memWriteE, aluControlE, aluSrcE, regDstE,
                  branchE, rd1E, rd2E, rsE, rtE, rdE, signImmE};

    // Reference model state: what the execute slot should hold.
    slot_t expSlot;
    logic  expValid;
    int    expCnt;

    int testCnt = 0;
    int failCnt = 0;

    always #5 clk = ~clk;

    id_ex_pipe_reg #(
        .DATA_WIDTH(DATA_WIDTH),
        .REG_AW    (REG_AW),
        .CNT_W     (CNT_W)
    ) dut (
        .i_CLK        (clk),
        .i_RST        (rst),
        .i_StallE     (stall),
        .i_FlushE     (flush),
        .i_RegWriteD  (din.regWrite),
        .i_MemtoRegD  (din.memtoReg),
        .i_MemWriteD  (din.memWrite),
        .i_ALUControlD(din.aluControl),
        .i_ALUSrcD    (din.aluSrc),
        .i_RegDstD    (din.regDst),
        .i_BranchD    (din.branch),
        .i_RD1D       (din.rd1),
        .i_RD2D       (din.rd2),
        .i_RsD        (din.rs),
        .i_RtD        (din.rt),
        .i_RdD        (din.rd),
        .i_SignImmD   (din.signImm),
        .o_RegWriteE  (regWriteE),
        .o_MemtoRegE  (memtoRegE),
        .o_MemWriteE  (memWriteE),
        .o_ALUControlE(aluControlE),
        .o_ALUSrcE    (aluSrcE),
        .o_RegDstE    (regDstE),
        .o_BranchE    (branchE),
        .o_RD1E       (rd1E),
        .o_RD2E       (rd2E),
        .o_RsE        (rsE),
        .o_RtE        (rtE),
        .o_RdE        (rdE),
        .o_SignImmE   (signImmE),
        .o_ValidE     (validE),
        .o_BubbleCnt  (bubbleCnt)
    );

    task automatic check(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        testCnt++;
        assert (observed === expected)
        else begin
            failCnt++;
            $error("FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    // Slot-level view: reset empties the slot, a flush empties it and adds a
    // bubble to the tally, otherwise the slot takes the decode word unless held.
    task automatic modelEdge();
        if (rst) begin
            expSlot  = '0;
            expValid = 1'b0;
            expCnt   = 0;
        end else if (flush) begin
            expSlot  = '0;
            expValid = 1'b0;
            expCnt   = (expCnt < CNT_MAX) ? expCnt + 1 : CNT_MAX;
        end else if (!stall) begin
            expSlot  = din;
            expValid = 1'b1;
        end
    endtask

    task automatic checkAll(input string tag);
        check({tag, ".ctrl"}, 64'({obs.regWrite, obs.memtoReg, obs.memWrite, obs.aluControl,
                                   obs.aluSrc, obs.regDst, obs.branch}),
                              64'({expSlot.regWrite, expSlot.memtoReg, expSlot.memWrite,
                                   expSlot.aluControl, expSlot.aluSrc, expSlot.regDst,
                                   expSlot.branch}));
        check({tag, ".rd1"},  64'(obs.rd1), 64'(expSlot.rd1));
        check({tag, ".rd2"},  64'(obs.rd2), 64'(expSlot.rd2));
        check({tag, ".regs"}, 64'({obs.rs, obs.rt, obs.rd}),
                              64'({expSlot.rs, expSlot.rt, expSlot.rd}));
        check({tag, ".imm"},  64'(obs.signImm), 64'(expSlot.signImm));
        check({tag, ".valid"}, 64'(validE), 64'(expValid));
        check({tag, ".cnt"},  64'(bubbleCnt), 64'(expCnt));
    endtask

    // One clock edge: inputs are already stable, model follows the edge,
    // outputs are sampled 1 time unit later.
    task automatic step(input string tag);
        @(posedge clk);
        modelEdge();
        #1;
        checkAll(tag);
    endtask

    function automatic slot_t randSlot();
        slot_t s;
        s = {$urandom, $urandom, $urandom, $urandom};
        return s;
    endfunction

    initial begin
        rst = 1'b0; stall = 1'b0; flush = 1'b0;
        expSlot = '0; expValid = 1'b0; expCnt = 0;

        // Reset with all-ones decode data.
        @(negedge clk);
        rst = 1'b1; din = '1;
        step("reset");
        check("reset.allZero", 64'({obs, validE, bubbleCnt}) , 64'(0));

        // Pass-through.
        rst = 1'b0; din = '0;
        din.rd1 = 32'hDEADBEEF; din.aluControl = 3'b010; din.regWrite = 1'b1;
        step("pass");
        check("pass.rd1", 64'(rd1E), 64'(32'hDEADBEEF));
        check("pass.alu", 64'(aluControlE), 64'(3'b010));

        // Stall holds rt=9 for three cycles, then 17 appears.
        din = randSlot(); din.rt = 5'd9;
        step("stallLoad");
        stall = 1'b1; din.rt = 5'd17;
        for (int i = 0; i < 3; i++) begin
            step("stallHold");
            check("stall.rt", 64'(rtE), 64'(5'd9));
        end
        stall = 1'b0;
        step("stallRelease");
        check("release.rt", 64'(rtE), 64'(5'd17));

        // Flush and stall together: bubble wins, counter 0 -> 1.
        flush = 1'b1; stall = 1'b1; din.memWrite = 1'b1;
        step("flushStall");
        check("flushStall.memWrite", 64'(memWriteE), 64'(0));
        check("flushStall.cnt", 64'(bubbleCnt), 64'(1));

        // Saturation over 20 flushes, with undefined decode data.
        stall = 1'b0; din = 'x;
        for (int i = 0; i < 20; i++) step("flushSat");
        check("sat.cnt", 64'(bubbleCnt), 64'(4'hF));

        // Stall keeps a saturated counter and the bubble in place.
        flush = 1'b0; stall = 1'b1; din = randSlot();
        step("satStall");

        // Reset while stalling.
        rst = 1'b1;
        step("rstStall");
        check("rstStall.cnt", 64'(bubbleCnt), 64'(0));
        rst = 1'b0; stall = 1'b0;

        // Randomized traffic.
        for (int i = 0; i < 400; i++) begin
            rst   = ($urandom_range(0, 39) == 0);
            flush = ($urandom_range(0, 4) == 0);
            stall = ($urandom_range(0, 3) == 0);
            din   = (flush && $urandom_range(0, 1) == 1) ? 'x : randSlot();
            step("random");
        end

        $display("[TB] %0d tests run, %0d failed", testCnt, failCnt);
        $finish;
    end

endmodule
`default_nettype wire
